if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 stall  input  1  hazard hold; IF/ID register keeps its contents.
REQ-005 redirect_valid  input  1  taken branch/jump; flushes IF/ID and restarts fetch.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request; transfer when valid&ready.
REQ-009 imem_req_addr  output  32  word address of request; equals internal pc.
REQ-010 imem_rsp_valid  input  1  instruction data valid; never asserted without an outstanding request.
REQ-011 imem_rsp_data  input  32  fetched instruction.
REQ-012 if_id_pc, if_id_instr  output  32 each  IF/ID register contents for the decode stage.
REQ-013 if_id_valid  output  1  IF/ID holds a live instruction.
REQ-014 fetch_misaligned  output  1  sticky misaligned-redirect flag (macro-dependent, REQ-031).

Function
REQ-015 States: FETCH (issue request), WAIT (one request outstanding), HOLD (response buffered during stall), DROP (discard response of killed request).
REQ-016 At most one request outstanding; request pc latched into req_pc when accepted; pc<=pc+4 on acceptance.
REQ-017 imem_req_valid=1 in FETCH, and in WAIT in the cycle imem_rsp_valid=1, stall=0, redirect_valid=0 (back-to-back fetch); 0 otherwise.
REQ-018 FETCH: accept -> WAIT; not accepted -> FETCH.
REQ-019 WAIT, rsp_valid, stall=0: load IF/ID {req_pc, rsp_data, valid=1}; stay WAIT if new request accepted, else FETCH.
REQ-020 WAIT, rsp_valid, stall=1: capture {req_pc, rsp_data} in hold buffer -> HOLD; IF/ID unchanged.
REQ-021 HOLD, stall=0: load hold buffer into IF/ID with valid=1 -> FETCH.
REQ-022 IF/ID update when stall=0 and no instruction delivered this cycle: if_id_valid<=0 (bubble); pc/instr unchanged.
REQ-023 redirect_valid=1 (overrides stall, any state): if_id_valid<=0; pc<=redirect_pc; hold buffer discarded; no request issued that cycle.
REQ-024 Redirect next-state: FETCH->FETCH; WAIT with rsp_valid same cycle -> FETCH (response dropped); WAIT without rsp_valid -> DROP; HOLD->FETCH; DROP->DROP.
REQ-025 DROP: on rsp_valid discard data -> FETCH; no request issued in DROP.
REQ-026 Zero-wait memory (ready=1, response one cycle after acceptance), no stall: one instruction per cycle into IF/ID after a 2-cycle start-up latency.
REQ-027 pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-028 On reset: state=FETCH, pc=RESET_PC, req_pc=0, hold buffer=0, if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013 (NOP), fetch_misaligned=0.
REQ-029 Reset mid-request: outstanding transaction abandoned; the memory is reset on the same reset, so no stale response arrives.
REQ-030 First request (addr=RESET_PC) is presented in the first clk edge-cycle after reset deasserts.

Configuration
REQ-031 IF_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 and enters DROP or FETCH per REQ-024, then halts further requests until reset; undefined: redirect_pc[1:0] forced to 2'b00, fetch_misaligned tied 0.

Verification
REQ-032 Reset, ready=1, 1-cycle response, no stall -> if_id_pc sequence 0,4,8,12 on consecutive cycles, if_id_valid=1 from cycle 2.
REQ-033 stall=1 for 3 cycles while response for pc=8 returns -> IF/ID holds pc=4; pc=8 appears the cycle after stall drops; no instruction lost or duplicated.
REQ-034 redirect_valid=1, redirect_pc=32'h100 while WAIT with response delayed 3 cycles -> stale response dropped; next if_id_pc=32'h100; if_id_valid=0 in between.
REQ-035 redirect and stall asserted together with valid IF/ID -> if_id_valid=0 next cycle.
REQ-036 pc=32'hFFFF_FFFC fetched -> next imem_req_addr=0.
REQ-037 IF_MISALIGN_TRAP_EN defined, redirect_pc=32'h102 -> fetch_misaligned=1, imem_req_valid stays 0 until reset; undefined -> next request addr=32'h100.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a single-outstanding-request
// memory interface and an IF/ID pipeline register.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               decode hazard hold; IF/ID keeps its contents
//   redirect_valid/_pc  taken branch/jump; flushes IF/ID, restarts fetch
//   imem_req_*          fetch request (valid/ready handshake, word address)
//   imem_rsp_*          instruction return for the outstanding request
//   if_id_pc/_instr/_valid  IF/ID register seen by decode
//   fetch_misaligned    sticky flag for a misaligned redirect target
//
// Configuration macro: IF_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned target sets fetch_misaligned
//               and stops all further fetch requests until reset.
//   undefined : redirect_pc[1:0] is ignored (forced to 0), flag tied low.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,  // issue a request
        S_WAIT,   // one request outstanding
        S_HOLD,   // response parked while decode is stalled
        S_DROP    // waiting to swallow the response of a killed request
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, req_pc_q;
    logic [31:0] hold_pc_q, hold_instr_q;
    logic [31:0] if_pc_q, if_instr_q;
    logic        if_vld_q;

    logic        req_v, accept;
    logic        deliver, capture;
    logic [31:0] del_pc, del_instr;
    logic [31:0] redir_tgt;
    logic        halt;

`ifdef IF_MISALIGN_TRAP_EN
    logic        mis_q;

    assign redir_tgt = redirect_pc;
    assign halt      = mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mis_q <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            mis_q <= 1'b1;
    end

    assign fetch_misaligned = mis_q;
`else
    assign redir_tgt        = redirect_pc & 32'hFFFF_FFFC;
    assign halt             = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // Request: always in FETCH (unless trapped); in WAIT only when the
    // current response is consumed this cycle, which keeps the pipe full
    // at one instruction per cycle without ever having two in flight.
    always_comb begin
        req_v = 1'b0;
        if (!redirect_valid) begin
            case (state_q)
                S_FETCH: req_v = !halt;
                S_WAIT:  req_v = imem_rsp_valid && !stall;
                default: req_v = 1'b0;
            endcase
        end
    end

    assign accept         = req_v && imem_req_ready;
    assign imem_req_valid = req_v;
    assign imem_req_addr  = pc_q;

    always_comb begin
        state_d   = state_q;
        deliver   = 1'b0;
        capture   = 1'b0;
        del_pc    = hold_pc_q;
        del_instr = hold_instr_q;
        case (state_q)
            S_FETCH: if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (stall) begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        deliver   = 1'b1;
                        del_pc    = req_pc_q;
                        del_instr = imem_rsp_data;
                        state_d   = accept ? S_WAIT : S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    deliver = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DROP: if (imem_rsp_valid) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        // Redirect wins over everything; a request still in flight with no
        // response yet must be drained in DROP so its data is never used.
        if (redirect_valid) begin
            deliver = 1'b0;
            capture = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rsp_valid ? S_FETCH : S_DROP;
                S_DROP:  state_d = S_DROP;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= NOP;
            if_vld_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (redirect_valid) begin
                pc_q <= redir_tgt;
            end else if (accept) begin
                pc_q     <= pc_q + 32'd4;
                req_pc_q <= pc_q;
            end

            if (redirect_valid) begin
                hold_pc_q    <= 32'h0;
                hold_instr_q <= 32'h0;
            end else if (capture) begin
                hold_pc_q    <= req_pc_q;
                hold_instr_q <= imem_rsp_data;
            end

            // Unstalled cycle with nothing to deliver inserts a bubble.
            if (redirect_valid) begin
                if_vld_q <= 1'b0;
            end else if (!stall) begin
                if_vld_q <= deliver;
                if (deliver) begin
                    if_pc_q    <= del_pc;
                    if_instr_q <= del_instr;
                end
            end
        end
    end

    assign if_id_pc    = if_pc_q;
    assign if_id_instr = if_instr_q;
    assign if_id_valid = if_vld_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_misaligned;

    int total = 0;
    int bad   = 0;

    // memory model: one pending request, answered mem_lat cycles after acceptance
    bit          mem_pend;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;

    // what happened in the most recent tick (sampled just before the edge)
    bit          acc;
    bit          req_seen;
    bit          overlap;
    logic [31:0] acc_addr;

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr),
        .if_id_valid      (if_id_valid),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: called at a negedge with control inputs already set,
    // returns at the next negedge with post-edge outputs stable.
    task automatic tick;
        imem_rsp_valid = mem_pend && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? insn(mem_addr) : 32'hDEAD_BEEF;
        #1;
        req_seen = imem_req_valid;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        overlap  = acc && mem_pend && !imem_rsp_valid;
        @(posedge clk);
        if (imem_rsp_valid) mem_pend = 1'b0;
        if (mem_pend) mem_cnt--;
        if (acc) begin
            mem_pend = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = mem_lat - 1;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mem_pend       = 1'b0;
        mem_cnt        = 0;
        mem_lat        = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset_dut();
        imem_req_ready = 1'b1;
        repeat (3) tick();
        // reset in the middle of traffic
        reset = 1'b1;
        mem_pend = 1'b0;
        #1;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", if_id_valid); end
        total++; if (if_id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", if_id_pc); end
        total++; if (if_id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h want=00000013", if_id_instr); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_req_addr); end
        total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b want=0", fetch_misaligned); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        total++; if (!(acc && acc_addr == 32'h0)) begin bad++; $display("FAIL first_req acc=%b addr=%h want acc=1 addr=0", acc, acc_addr); end
    endtask

    task automatic test_stream;
        reset_dut();
        imem_req_ready = 1'b1;
        mem_lat = 1;
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL startup_bubble got=%b want=0", if_id_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i) || if_id_instr !== insn(32'(4 * i))) begin
                bad++;
                $display("FAIL stream%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, if_id_valid, if_id_pc, if_id_instr, 32'(4 * i), insn(32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall;
        reset_dut();
        imem_req_ready = 1'b1;
        mem_lat = 1;
        repeat (3) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin
                bad++; $display("FAIL stall_hold%0d got v=%b pc=%h want v=1 pc=4", i, if_id_valid, if_id_pc);
            end
        end
        stall = 1'b0;
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== insn(32'h8)) begin
            bad++; $display("FAIL stall_release got v=%b pc=%h ins=%h want v=1 pc=8", if_id_valid, if_id_pc, if_id_instr);
        end
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL stall_bubble got=%b want=0", if_id_valid); end
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC) begin
            bad++; $display("FAIL stall_next got v=%b pc=%h want v=1 pc=c", if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_redirect_drop;
        bit          seen_acc = 1'b0;
        bit          seen_vld = 1'b0;
        logic [31:0] first_acc = 32'hX;
        reset_dut();
        imem_req_ready = 1'b1;
        mem_lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rdrop_flush got=%b want=0", if_id_valid); end
        for (int i = 0; i < 12 && !seen_vld; i++) begin
            tick();
            if (acc && !seen_acc) begin seen_acc = 1'b1; first_acc = acc_addr; end
            if (if_id_valid) seen_vld = 1'b1;
        end
        total++; if (!seen_vld) begin bad++; $display("FAIL rdrop_timeout got no valid within 12 cycles want valid"); end
        total++; if (if_id_pc !== 32'h100 || if_id_instr !== insn(32'h100)) begin
            bad++; $display("FAIL rdrop_pc got pc=%h ins=%h want pc=100 ins=%h", if_id_pc, if_id_instr, insn(32'h100));
        end
        total++; if (first_acc !== 32'h100) begin bad++; $display("FAIL rdrop_addr got=%h want=100", first_acc); end
    endtask

    task automatic test_redirect_stall;
        bit seen_vld = 1'b0;
        reset_dut();
        imem_req_ready = 1'b1;
        mem_lat = 1;
        repeat (3) tick();
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL rs_pre got=%b want=1", if_id_valid); end
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rs_flush got=%b want=0", if_id_valid); end
        for (int i = 0; i < 8 && !seen_vld; i++) begin
            tick();
            if (if_id_valid) seen_vld = 1'b1;
        end
        total++; if (!seen_vld || if_id_pc !== 32'h200) begin
            bad++; $display("FAIL rs_target got v=%b pc=%h want v=1 pc=200", seen_vld, if_id_pc);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] accq[$];
        logic [31:0] delq[$];
        reset_dut();
        imem_req_ready = 1'b1;
        mem_lat = 1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 12 && delq.size() < 3; i++) begin
            tick();
            if (acc) accq.push_back(acc_addr);
            if (if_id_valid) delq.push_back(if_id_pc);
        end
        total++; if (accq.size() < 3 || accq[1] !== 32'hFFFF_FFFC || accq[2] !== 32'h0) begin
            bad++; $display("FAIL wrap_req got n=%0d want reqs fffffff8,fffffffc,00000000", accq.size());
        end
        total++; if (delq.size() < 3 || delq[0] !== 32'hFFFF_FFF8 || delq[2] !== 32'h0) begin
            bad++; $display("FAIL wrap_ifid got n=%0d want pcs fffffff8,fffffffc,00000000", delq.size());
        end
    endtask

    task automatic test_misalign;
        reset_dut();
        imem_req_ready = 1'b1;
        mem_lat = 1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        begin
            int nreq = 0;
            total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", fetch_misaligned); end
            for (int i = 0; i < 8; i++) begin
                tick();
                if (req_seen) nreq++;
            end
            total++; if (nreq != 0) begin bad++; $display("FAIL mis_halt got reqs=%0d want=0", nreq); end
        end
`else
        begin
            bit seen = 1'b0;
            total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b want=0", fetch_misaligned); end
            for (int i = 0; i < 8 && !seen; i++) begin
                tick();
                if (acc) seen = 1'b1;
            end
            total++; if (!seen || acc_addr !== 32'h100) begin
                bad++; $display("FAIL mis_align got acc=%b addr=%h want acc=1 addr=100", seen, acc_addr);
            end
        end
`endif
    endtask

    // Randomised traffic checked against an in-order stream model: requests
    // must walk the fetch pointer, IF/ID must deliver consecutive pcs with the
    // memory's data, restart at each redirect target, and freeze under stall.
    task automatic test_random;
        logic [31:0] fptr = 32'h0;
        logic [31:0] dptr = 32'h0;
        logic [31:0] p_pc, p_ins, p_rpc;
        bit          p_vld, p_stall, p_redir;
        int          ndeliv = 0;
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            stall          = ($urandom % 4) == 0;
            redirect_valid = ($urandom % 20) == 0;
            if (($urandom % 6) == 0)
                redirect_pc = 32'hFFFF_FFE0 + (32'($urandom_range(0, 7)) << 2);
            else
                redirect_pc = $urandom & 32'h0000_0FFC;
            imem_req_ready = ($urandom % 4) != 0;
            mem_lat        = $urandom_range(1, 3);
            p_pc = if_id_pc; p_ins = if_id_instr; p_vld = if_id_valid;
            p_stall = stall; p_redir = redirect_valid; p_rpc = redirect_pc;
            tick();
            total++; if (p_redir && req_seen) begin bad++; $display("FAIL rnd_req_on_redirect cyc=%0d got=1 want=0", c); end
            total++; if (overlap) begin bad++; $display("FAIL rnd_two_outstanding cyc=%0d got=2 want<=1", c); end
            if (acc) begin
                total++;
                if (acc_addr !== fptr) begin bad++; $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", c, acc_addr, fptr); end
                fptr += 32'd4;
            end
            if (p_redir) begin
                fptr = p_rpc;
                dptr = p_rpc;
                total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b want=0", c, if_id_valid); end
            end else if (p_stall) begin
                total++;
                if (if_id_valid !== p_vld || if_id_pc !== p_pc || if_id_instr !== p_ins) begin
                    bad++; $display("FAIL rnd_stall_hold cyc=%0d got v=%b pc=%h want v=%b pc=%h", c, if_id_valid, if_id_pc, p_vld, p_pc);
                end
            end else if (if_id_valid) begin
                total++;
                if (if_id_pc !== dptr || if_id_instr !== insn(dptr)) begin
                    bad++; $display("FAIL rnd_deliver cyc=%0d got pc=%h ins=%h want pc=%h ins=%h", c, if_id_pc, if_id_instr, dptr, insn(dptr));
                end
                dptr += 32'd4;
                ndeliv++;
            end
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        total++; if (ndeliv < 50) begin bad++; $display("FAIL rnd_progress got=%0d want>=50", ndeliv); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_stall();
        test_wrap();
        test_random();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
